mem_wb_stage: RTL and testbench

Parametrised MEM→WB pipeline stage with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It carries the data address bus, the data bus, the writeback destination select, and the load/store flags from the memory stage to the writeback stage. It replaces the fixed 32-bit free-running MEM/WB register so that writeback back-pressure and pipeline flushes are handled without losing or duplicating instructions. Stores and bubbles are always presented to writeback with the null destination select, so they never write the register file.

---
 rtl/mem_wb_stage.sv | 99 +++++++++
 tb/tb_mem_wb_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: valid/ready handshake with a two-entry skid buffer and flush.
// Stores and bubbles are always presented to writeback with the null destination select.
module mem_wb_stage #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              SEL_W    = 32,
  parameter logic [SEL_W-1:0] NULL_SEL = SEL_W'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] dbus_in,
  input  logic [DATA_W-1:0] databus_in,
  input  logic [SEL_W-1:0]  dsel_in,
  input  logic              load_in,
  input  logic              store_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] dbus_out,
  output logic [DATA_W-1:0] databus_out,
  output logic [SEL_W-1:0]  dsel_out,
  output logic              load_out,
  output logic              store_out,
  output logic [1:0]        occupancy
);
  typedef struct packed {
    logic [ADDR_W-1:0] dbus;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              load;
    logic              store;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_ent;
  logic   accept, drain, load_main, load_skid, promote;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Stores are squashed to the null select at capture, so WB never writes for them.
  assign in_ent = '{dbus:  dbus_in,
                    data:  databus_in,
                    sel:   store_in ? NULL_SEL : dsel_in,
                    load:  load_in,
                    store: store_in};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = ONE;
        ONE:     if (accept && !drain) state_nxt = FULL;
                 else if (!accept && drain) state_nxt = EMPTY;
        FULL:    if (drain) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready depends on registered state only, so there is no ready path from WB back to MEM.
  always_comb begin
    in_ready    = (state != FULL);
    out_valid   = (state != EMPTY);
    occupancy   = state;
    dbus_out    = main_q.dbus;
    databus_out = main_q.data;
    dsel_out    = out_valid ? main_q.sel : NULL_SEL;
    load_out    = out_valid & main_q.load;
    store_out   = out_valid & main_q.store;
  end

  // Payload only moves on accept or promotion; a flush suppresses both.
  assign load_main = accept & ~flush & ((state == EMPTY) | ((state == ONE) & drain));
  assign load_skid = accept & ~flush & (state == ONE) & ~drain;
  assign promote   = drain & ~flush & (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)    main_q <= in_ent;
      else if (promote) main_q <= skid_q;
      if (load_skid)    skid_q <= in_ent;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed vector table followed by randomised handshaking against a FIFO scoreboard.
module tb_mem_wb_stage;
  logic        clk = 0;
  logic        rst_n, flush, in_valid, in_ready, load_in, store_in;
  logic        out_valid, out_ready, load_out, store_out;
  logic [31:0] dbus_in, databus_in, dsel_in, dbus_out, databus_out, dsel_out;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dbus_in(dbus_in), .databus_in(databus_in), .dsel_in(dsel_in),
    .load_in(load_in), .store_in(store_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .dbus_out(dbus_out), .databus_out(databus_out), .dsel_out(dsel_out),
    .load_out(load_out), .store_out(store_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [1:0]  ls;          // {load, store}
    logic [31:0] dbus, dbd, dsel;
    logic [1:0]  e_occ;
    logic        e_ir, e_ov;
    logic [1:0]  e_ls;
    logic [31:0] e_dsel;
    logic        dck;         // compare held payload
    logic [31:0] e_dbus, e_dbd;
  } vec_t;

  typedef struct {
    logic [31:0] dbus, dbd, dsel;
    logic        ld, st;
  } ent_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic o,
                       input logic [1:0] ls, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] s);
    rst_n = r; flush = f; in_valid = iv; out_ready = o;
    load_in = ls[1]; store_in = ls[0];
    dbus_in = a; databus_in = d; dsel_in = s;
  endtask

  vec_t vt[22];
  ent_t q[$];

  initial begin
    //          rst fl iv or ls  dbus           dbd    dsel      occ ir ov e_ls e_dsel  dck e_dbus  e_dbd
    vt[0]  = '{0, 0, 1, 0, 2'b00, 32'hDEADBEEF, 32'h9, 32'h4,   2'd0, 1, 0, 2'b00, 32'h1,   1, 32'h0,   32'h0};
    vt[1]  = '{0, 0, 1, 0, 2'b00, 32'hDEADBEEF, 32'h9, 32'h4,   2'd0, 1, 0, 2'b00, 32'h1,   1, 32'h0,   32'h0};
    vt[2]  = '{1, 0, 1, 1, 2'b10, 32'h100,      32'hA1, 32'h4,  2'd1, 1, 1, 2'b10, 32'h4,   1, 32'h100, 32'hA1};
    vt[3]  = '{1, 0, 1, 1, 2'b00, 32'h104,      32'hB2, 32'h8,  2'd1, 1, 1, 2'b00, 32'h8,   1, 32'h104, 32'hB2};
    vt[4]  = '{1, 0, 1, 1, 2'b00, 32'h108,      32'hC3, 32'h10, 2'd1, 1, 1, 2'b00, 32'h10,  1, 32'h108, 32'hC3};
    vt[5]  = '{1, 0, 0, 1, 2'b00, 32'h0,        32'h0, 32'h0,   2'd0, 1, 0, 2'b00, 32'h1,   1, 32'h108, 32'hC3};
    vt[6]  = '{1, 0, 1, 0, 2'b00, 32'h200,      32'hD4, 32'h20, 2'd1, 1, 1, 2'b00, 32'h20,  1, 32'h200, 32'hD4};
    vt[7]  = '{1, 0, 1, 0, 2'b00, 32'h204,      32'hE5, 32'h40, 2'd2, 0, 1, 2'b00, 32'h20,  1, 32'h200, 32'hD4};
    vt[8]  = '{1, 0, 1, 0, 2'b00, 32'h208,      32'hF6, 32'h80, 2'd2, 0, 1, 2'b00, 32'h20,  1, 32'h200, 32'hD4};
    vt[9]  = '{1, 0, 0, 1, 2'b00, 32'h0,        32'h0, 32'h0,   2'd1, 1, 1, 2'b00, 32'h40,  1, 32'h204, 32'hE5};
    vt[10] = '{1, 0, 0, 1, 2'b00, 32'h0,        32'h0, 32'h0,   2'd0, 1, 0, 2'b00, 32'h1,   1, 32'h204, 32'hE5};
    vt[11] = '{1, 0, 1, 0, 2'b01, 32'h300,      32'h55, 32'h400, 2'd1, 1, 1, 2'b01, 32'h1,  1, 32'h300, 32'h55};
    vt[12] = '{1, 0, 1, 1, 2'b10, 32'h304,      32'h66, 32'h400, 2'd1, 1, 1, 2'b10, 32'h400, 1, 32'h304, 32'h66};
    vt[13] = '{1, 0, 1, 0, 2'b00, 32'h400,      32'h77, 32'h80, 2'd2, 0, 1, 2'b10, 32'h400, 1, 32'h304, 32'h66};
    vt[14] = '{1, 1, 1, 0, 2'b00, 32'h500,      32'h88, 32'h2,  2'd0, 1, 0, 2'b00, 32'h1,   0, 32'h0,   32'h0};
    vt[15] = '{1, 0, 0, 1, 2'b00, 32'h0,        32'h0, 32'h0,   2'd0, 1, 0, 2'b00, 32'h1,   0, 32'h0,   32'h0};
    vt[16] = '{1, 0, 1, 0, 2'b00, 32'h600,      32'h99, 32'h100, 2'd1, 1, 1, 2'b00, 32'h100, 1, 32'h600, 32'h99};
    vt[17] = '{1, 1, 1, 0, 2'b00, 32'h604,      32'hAA, 32'h200, 2'd0, 1, 0, 2'b00, 32'h1,   0, 32'h0,   32'h0};
    vt[18] = '{1, 0, 0, 1, 2'b00, 32'h0,        32'h0, 32'h0,   2'd0, 1, 0, 2'b00, 32'h1,   0, 32'h0,   32'h0};
    vt[19] = '{0, 1, 1, 1, 2'b00, 32'h0,        32'h0, 32'h0,   2'd0, 1, 0, 2'b00, 32'h1,   1, 32'h0,   32'h0};
    vt[20] = '{1, 0, 1, 1, 2'b00, 32'h700,      32'hBB, 32'h2,  2'd1, 1, 1, 2'b00, 32'h2,   1, 32'h700, 32'hBB};
    vt[21] = '{1, 0, 0, 1, 2'b00, 32'h0,        32'h0, 32'h0,   2'd0, 1, 0, 2'b00, 32'h1,   1, 32'h700, 32'hBB};

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].ordy, vt[i].ls, vt[i].dbus, vt[i].dbd, vt[i].dsel);
      @(negedge clk);
      chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vt[i].e_occ));
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vt[i].e_ir));
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
      chk($sformatf("v%0d dsel_out", i), 64'(dsel_out), 64'(vt[i].e_dsel));
      chk($sformatf("v%0d load/store", i), 64'({load_out, store_out}), 64'(vt[i].e_ls));
      if (vt[i].dck) begin
        chk($sformatf("v%0d dbus_out", i), 64'(dbus_out), 64'(vt[i].e_dbus));
        chk($sformatf("v%0d databus_out", i), 64'(databus_out), 64'(vt[i].e_dbd));
      end
    end

    // Random phase: the first cycle is a reset so the scoreboard starts aligned.
    for (int c = 0; c < 10000; c++) begin
      logic r, f, iv, o, acc, drn;
      logic [1:0] ls;
      ent_t e;
      r  = !(c == 0 || $urandom_range(499) == 0);
      f  = ($urandom_range(49) == 0);
      iv = ($urandom_range(99) < 65);
      o  = ($urandom_range(1) == 1);
      ls = 2'($urandom_range(2));
      e.dbus = $urandom; e.dbd = $urandom; e.dsel = 32'h1 << $urandom_range(31);
      e.ld = ls[1]; e.st = ls[0];
      drive(r, f, iv, o, ls, e.dbus, e.dbd, e.dsel);
      if (e.st) e.dsel = 32'h1;
      acc = iv && (q.size() < 2);
      drn = o && (q.size() > 0);
      if (!r || f) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      @(negedge clk);
      chk("rnd occupancy", 64'(occupancy), 64'(q.size()));
      chk("rnd in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("rnd out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd dbus_out", 64'(dbus_out), 64'(q[0].dbus));
        chk("rnd databus_out", 64'(databus_out), 64'(q[0].dbd));
        chk("rnd dsel_out", 64'(dsel_out), 64'(q[0].dsel));
        chk("rnd load/store", 64'({load_out, store_out}), 64'({q[0].ld, q[0].st}));
      end else begin
        chk("rnd idle dsel_out", 64'(dsel_out), 64'h1);
        chk("rnd idle load/store", 64'({load_out, store_out}), 64'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
